index_histogram: RTL and testbench
==================================

# index_histogram

Downstream consumer of the leading-one index stream produced by the bit-location stage. It accepts 3-bit index values over a valid/ready handshake and counts how often each index value occurs, using one counter per bin. After every frame of FRAME_LEN accepted samples it streams the eight bin counts out over a second valid/ready handshake, clearing each bin as it goes. It then resumes accumulating.

## Interface
Parameters:
- FRAME_LEN, default 16: samples per frame; legal range 1..65535.
- CNT_W, default 8: bin counter width; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- vld_src  input  1  upstream valid; connects to the bit-location stage's vld_sink.
- index_in  input  3  upstream index; sampled when vld_src & rdy_src.
- rdy_src  output  1  ready to upstream.
- vld_sink  output  1  bin-count beat valid.
- bin_out  output  3  bin number of the current beat.
- count_out  output  CNT_W  count for bin_out.
- last_out  output  1  high on the beat for bin 7.
- rdy_sink  input  1  downstream ready.

## Operation
- Internal state:
  - 8 x CNT_W bin counters.
  - Sample counter, 16 bits.
  - 3-bit drain pointer ptr.
  - 1-bit state: ACCUM or DRAIN.
- Reset (rst high at a clock edge):
  - State goes to ACCUM; all bins, the sample counter and ptr go to 0.
  - Outputs reset to vld_sink=0, bin_out=0, count_out=0, last_out=0.
  - rdy_src is forced to 0 in any cycle where rst is high.
  - Reset is honoured in any state, including mid-drain. A partial frame or partial drain is discarded with no beats emitted.
- ACCUM:
  - rdy_src=1 and vld_sink=0.
  - On accept (vld_src & rdy_src): bin[index_in] increments by 1, saturating at 2^CNT_W-1. The sample counter increments by 1.
  - When an accept occurs with the sample counter equal to FRAME_LEN-1: the sample counter goes to 0, ptr to 0, and state to DRAIN. That final sample is counted.
  - With no accept, nothing changes, whatever value index_in has.
- DRAIN:
  - rdy_src=0, so upstream stalls and no sample is dropped or counted.
  - vld_sink=1, bin_out=ptr, count_out=bin[ptr], last_out=(ptr==7).
  - On a transfer (vld_sink & rdy_sink): bin[ptr] clears to 0 and ptr increments.
  - If the transfer is for ptr==7: state goes to ACCUM and ptr wraps to 0.
  - Without rdy_sink, all outputs hold stable. vld_sink never drops before its transfer completes.
- Bins are only ever cleared by a drain transfer or by reset, so every frame starts with all counts at 0.
- Arithmetic:
  - Bin increment is unsigned and saturating.
  - Sample counter compare is an exact equality against FRAME_LEN-1.
  - The sum of the counts in a frame equals FRAME_LEN unless saturation occurred.

## Timing
- Accept-to-count: a bin update is visible in the cycle after the accepting edge.
- Last sample of a frame: it is accepted at edge N, and vld_sink=1 from the cycle after edge N. rdy_src=0 in that same cycle.
- Drain length: 8 transfers. With rdy_sink held high, this is exactly 8 cycles of vld_sink=1.
- Return to ACCUM: rdy_src=1 in the cycle after the bin-7 transfer. Throughput is FRAME_LEN+8 cycles per frame at best.
- Outputs are registered state decoded combinationally from the state, ptr and bins, with no input-to-output combinational path. Exception: the reset gating of rdy_src.
- Simultaneous events:
  - Upstream and downstream handshakes never occur in the same cycle, because rdy_src and vld_sink are mutually exclusive.
  - rst high overrides any handshake in the same cycle.
- FRAME_LEN=1: every accept triggers a drain. The single non-zero beat carries count 1.

## Test plan
- Reset: hold rst for 3 cycles with vld_src=1 -> rdy_src=0 and vld_sink=0 during reset. rdy_src=1 on the first cycle after rst falls. Nothing is counted while rst is high.
- Single-bin frame: FRAME_LEN=16, CNT_W=8, 16 back-to-back samples of index 3, rdy_sink=1 -> 8 consecutive beats with bins 0..7 and counts 0,0,0,16,0,0,0,0. last_out appears only on bin 7. rdy_src=1 on the next cycle.
- Mixed frame with bubbles: indices 0,7,7,2 repeated 4 times, with vld_src low every other cycle -> counts 4,0,4,0,0,0,0,8. Upstream-to-drain start is 1 cycle after the 16th accept.
- Backpressure: during the drain, drop rdy_sink for 5 cycles while bin 2 is presented -> bin_out=2 and count_out are held unchanged, with no bin skipped or duplicated. vld_src stays stalled (rdy_src=0) throughout.
- Saturation: CNT_W=4, FRAME_LEN=20, all samples index 5 -> bin 5 reports 15 and all others 0. The next frame of 20 samples of index 1 reports bin 1=15 and bin 5=0, confirming bins were cleared.
- Reset mid-drain: assert rst after the bin-3 transfer -> vld_sink=0 the next cycle and state is ACCUM. The following frame of 16 samples of index 6 reports only bin 6=16, with no residue from the aborted frame.

Source files
------------

// File: rtl/index_histogram.sv
// index_histogram: per-frame histogram of 3-bit leading-one indices.
// Accumulates FRAME_LEN accepted samples into eight saturating bins, then
// streams the eight bin counts out (bin 0..7), clearing each bin as its beat
// transfers, and returns to accumulating.
//
// Handshake semantics (both ports): a beat transfers on a rising edge where
// valid and ready are both high. A producer holds valid and its payload stable
// until the transfer; ready may change freely. rdy_src and vld_sink are never
// high together, so upstream and downstream transfers never share a cycle.
module index_histogram #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_src,
  input  logic [2:0]       index_in,
  output logic             rdy_src,
  output logic             vld_sink,
  output logic [2:0]       bin_out,
  output logic [CNT_W-1:0] count_out,
  output logic             last_out,
  input  logic             rdy_sink
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [15:0]      LAST_SMP = 16'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bin_q [8];
  logic [CNT_W-1:0] bin_d [8];
  logic [15:0]      smp_q, smp_d;
  logic [2:0]       ptr_q, ptr_d;

  logic accept;
  logic xfer;
  logic frame_done;

  assign accept     = vld_src & rdy_src;
  assign xfer       = vld_sink & rdy_sink;
  assign frame_done = accept && (smp_q == LAST_SMP);

  // State register plus datapath flops; reset discards any partial frame/drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      smp_q   <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        bin_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < 8; i++) begin
        bin_q[i] <= bin_d[i];
      end
    end
  end

  // Next-state: frame completion enters DRAIN, the bin-7 transfer leaves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (frame_done) state_d = ST_DRAIN;
      ST_DRAIN: if (xfer && (ptr_q == 3'd7)) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  // Output decode from registered state; rst gates rdy_src so nothing is
  // accepted while reset is asserted.
  always_comb begin
    rdy_src   = 1'b0;
    vld_sink  = 1'b0;
    bin_out   = '0;
    count_out = '0;
    last_out  = 1'b0;
    case (state_q)
      ST_ACCUM: rdy_src = ~rst;
      ST_DRAIN: begin
        vld_sink  = 1'b1;
        bin_out   = ptr_q;
        count_out = bin_q[ptr_q];
        last_out  = (ptr_q == 3'd7);
      end
      default: ;
    endcase
  end

  // Datapath: saturating bin increment on accept, bin clear on drain transfer.
  // accept and xfer are mutually exclusive, so the two updates never collide.
  always_comb begin
    bin_d = bin_q;
    smp_d = smp_q;
    ptr_d = ptr_q;
    if (accept) begin
      if (bin_q[index_in] != CNT_MAX) begin
        bin_d[index_in] = bin_q[index_in] + CNT_W'(1);
      end
      if (smp_q == LAST_SMP) begin
        smp_d = '0;
        ptr_d = '0;
      end else begin
        smp_d = smp_q + 16'd1;
      end
    end
    if (xfer) begin
      bin_d[ptr_q] = '0;
      ptr_d        = ptr_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_index_histogram.sv
// Bench for index_histogram: two instances (16/8 and 20/4) share one stimulus
// front end selected by sel_b; a frame-level histogram model fills exp_q.
module tb_index_histogram;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared front end ----------------
  logic       sel_b = 1'b0;
  logic       vld_src = 1'b0;
  logic [2:0] index_in = '0;
  logic       rdy_sink = 1'b0;

  logic       rdy_src, vld_sink, last_out;
  logic [2:0] bin_out;
  logic [7:0] count_out;

  logic       vld_src_a, rdy_src_a, vld_sink_a, last_out_a, rdy_sink_a;
  logic [2:0] bin_out_a;
  logic [7:0] count_out_a;
  logic       vld_src_b, rdy_src_b, vld_sink_b, last_out_b, rdy_sink_b;
  logic [2:0] bin_out_b;
  logic [3:0] count_out_b;

  assign vld_src_a  = vld_src & (~sel_b | rst);
  assign vld_src_b  = vld_src & (sel_b | rst);
  assign rdy_sink_a = rdy_sink & ~sel_b;
  assign rdy_sink_b = rdy_sink & sel_b;

  assign rdy_src   = sel_b ? rdy_src_b   : rdy_src_a;
  assign vld_sink  = sel_b ? vld_sink_b  : vld_sink_a;
  assign last_out  = sel_b ? last_out_b  : last_out_a;
  assign bin_out   = sel_b ? bin_out_b   : bin_out_a;
  assign count_out = sel_b ? {4'b0000, count_out_b} : count_out_a;

  index_histogram #(.FRAME_LEN(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .vld_src(vld_src_a), .index_in(index_in),
    .rdy_src(rdy_src_a), .vld_sink(vld_sink_a), .bin_out(bin_out_a),
    .count_out(count_out_a), .last_out(last_out_a), .rdy_sink(rdy_sink_a)
  );

  index_histogram #(.FRAME_LEN(20), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .vld_src(vld_src_b), .index_in(index_in),
    .rdy_src(rdy_src_b), .vld_sink(vld_sink_b), .bin_out(bin_out_b),
    .count_out(count_out_b), .last_out(last_out_b), .rdy_sink(rdy_sink_b)
  );

  // ---------------- scoreboard ----------------
  // exp_q entry: {last, bin[2:0], count[7:0]}
  logic [11:0] exp_q[$];
  logic [2:0]  frame_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_frame_len = 16;
  int          cur_cnt_w     = 8;

  // Reference: histogram of the accepted frame, clipped at the counter max.
  task automatic model_frame();
    int occ[8];
    int maxc;
    int c;
    maxc = (1 << cur_cnt_w) - 1;
    for (int i = 0; i < 8; i++) occ[i] = 0;
    foreach (frame_q[i]) occ[frame_q[i]]++;
    for (int b = 0; b < 8; b++) begin
      c = (occ[b] > maxc) ? maxc : occ[b];
      exp_q.push_back({(b == 7), 3'(b), 8'(c)});
    end
    frame_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // bub: 0 none, 1 bubble before every sample, 2 random bubbles
  task automatic send_sample(input logic [2:0] idx, input int bub);
    int tries;
    logic [1:0] got;
    if (bub == 1 || (bub == 2 && $urandom_range(0, 1) == 1)) begin
      @(negedge clk);
      vld_src  = 1'b0;
      index_in = 3'($urandom);
      rdy_sink = 1'($urandom);
      #1;
    end
    tries = 0;
    do begin
      @(negedge clk);
      vld_src  = 1'b1;
      index_in = idx;
      rdy_sink = 1'($urandom);
      #1;
      tries++;
    end while (!rdy_src && tries < 20);
    got = {rdy_src, vld_sink};
    n_checks++;
    if (got !== 2'b10) begin
      n_fail++;
      $display("FAIL accum_ready: {rdy_src,vld_sink}=%b required 10", got);
    end
    frame_q.push_back(idx);
  endtask

  // mode: 0 constant idx, 1 pattern 0,7,7,2, 2 random
  task automatic send_frame(input int mode, input logic [2:0] idx, input int bub);
    logic [2:0] pat [4];
    logic [2:0] s;
    pat[0] = 3'd0; pat[1] = 3'd7; pat[2] = 3'd7; pat[3] = 3'd2;
    for (int i = 0; i < cur_frame_len; i++) begin
      case (mode)
        0:       s = idx;
        1:       s = pat[i % 4];
        default: s = 3'($urandom);
      endcase
      send_sample(s, bub);
    end
    model_frame();
  endtask

  // Drains starting the cycle after the last accept; every drain cycle is checked.
  task automatic drain(input int stall_bin, input int stall_len, input int abort_at);
    int b;
    int stalled;
    int cyc;
    logic hold;
    logic [11:0] e;
    logic [13:0] got, want;
    b = 0; stalled = 0; cyc = 0;
    while (b < abort_at && cyc < 40) begin
      @(negedge clk);
      vld_src  = 1'($urandom);
      index_in = 3'($urandom);
      hold     = (b == stall_bin) && (stalled < stall_len);
      rdy_sink = ~hold;
      #1;
      e    = (exp_q.size() > 0) ? exp_q[0] : 12'hxxx;
      got  = {vld_sink, rdy_src, last_out, bin_out, count_out};
      want = {1'b1, 1'b0, e};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL drain_beat%0d: {vld,rdy_src,last,bin,count}=%h required %h", b, got, want);
      end
      if (hold) stalled++;
      else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        b++;
      end
      cyc++;
    end
    if (abort_at == 8) begin
      @(negedge clk);
      vld_src  = 1'b0;
      rdy_sink = 1'($urandom);
      #1;
      n_checks++;
      if ({rdy_src, vld_sink} !== 2'b10) begin
        n_fail++;
        $display("FAIL return_accum: {rdy_src,vld_sink}=%b required 10", {rdy_src, vld_sink});
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] got;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst      = 1'b1;
      vld_src  = 1'b1;
      index_in = 3'($urandom);
      rdy_sink = 1'b1;
      #1;
      got = {rdy_src_a, vld_sink_a, rdy_src_b, vld_sink_b};
      n_checks++;
      if (got !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold: {rdy_a,vld_a,rdy_b,vld_b}=%b required 0000", got);
      end
    end
    @(negedge clk);
    rst     = 1'b0;
    vld_src = 1'b0;
    #1;
    got = {rdy_src_a, vld_sink_a, rdy_src_b, vld_sink_b};
    n_checks++;
    if (got !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_release: {rdy_a,vld_a,rdy_b,vld_b}=%b required 1010", got);
    end
  endtask

  task automatic test_single_bin();
    send_frame(0, 3'd3, 0);
    drain(8, 0, 8);
  endtask

  task automatic test_mixed_bubbles();
    send_frame(1, 3'd0, 1);
    drain(8, 0, 8);
  endtask

  task automatic test_backpressure();
    send_frame(2, 3'd0, 2);
    drain(2, 5, 8);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    vld_src = 1'b0;
    sel_b = 1'b1;
    cur_frame_len = 20;
    cur_cnt_w = 4;
    send_frame(0, 3'd5, 0);
    drain(8, 0, 8);
    send_frame(0, 3'd1, 2);
    drain($urandom_range(0, 7), 2, 8);
    @(negedge clk);
    vld_src = 1'b0;
    sel_b = 1'b0;
    cur_frame_len = 16;
    cur_cnt_w = 8;
  endtask

  task automatic test_reset_mid_drain();
    send_frame(2, 3'd0, 0);
    drain(8, 0, 4);
    exp_q.delete();
    @(negedge clk);
    rst      = 1'b1;
    vld_src  = 1'b1;
    rdy_sink = 1'b1;
    #1;
    n_checks++;
    if (rdy_src !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_rdy: rdy_src=%b required 0", rdy_src);
    end
    @(negedge clk);
    rst     = 1'b0;
    vld_src = 1'b0;
    #1;
    n_checks++;
    if ({rdy_src, vld_sink} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_reset_state: {rdy_src,vld_sink}=%b required 10", {rdy_src, vld_sink});
    end
    send_frame(0, 3'd6, 0);
    drain(8, 0, 8);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      send_frame(2, 3'd0, 2);
      drain($urandom_range(0, 7), $urandom_range(0, 4), 8);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_bin();
    test_mixed_bubbles();
    test_backpressure();
    test_saturation();
    test_reset_mid_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
